// File: rtl/twitchcore_cpu.sv
// twitchcore_cpu: seven-step multi-cycle RV32I core with word-addressed synchronous instruction and data ports.
// Define TWITCHCORE_ILLEGAL_TRAP_EN to trap on unknown opcodes / bad OP funct7 instead of treating them as NOPs.
module twitchcore_cpu (
  input  logic        clk,
  input  logic        resetn,
  output logic        trap,
  output logic [11:0] i_addr,
  input  logic [31:0] i_data,
  output logic [11:0] d_addr,
  input  logic [31:0] d_data
);
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [31:0] RESET_PC  = 32'h8000_0000;

  logic [6:0]  step_q, step_d;
  logic        step_2, step_4, step_6;
  logic [31:0] pc_q, pc_d, ins_q, ins_d, mepc_q, mepc_d;
  logic [31:0] alu_q, alu_d, target_q, target_d;
  logic [11:0] d_addr_q, d_addr_d;
  logic [1:0]  ea_lo_q, ea_lo_d;
  logic        pend_q, pend_d, trap_q, trap_d, take_q, take_d;
  logic [31:0] regs_q [0:31];
  logic [31:0] regs [0:31];

  logic [31:0] pc, ins;
  logic        pend;
  logic [6:0]  opcode;
  logic [2:0]  alu_func;
  logic        alu_alt;
  logic [31:0] alu_left, alu_right, alu_res, imm, sum;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] rs1_val, rs2_val;
  logic [13:0] ea;
  logic        funct7_ok, known, illegal, illegal_halt, writes_rd, br_take;
  logic        is_ecall, is_ebreak, is_mret, is_csr, csr_mepc_wr, halt;
  logic [31:0] csr_src, csr_wdata, load_val, rf_wdata;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic        rf_we;

  assign pc     = pc_q;
  assign ins    = ins_q;
  assign pend   = pend_q;
  assign trap   = trap_q;
  assign i_addr = pc_q[13:2];
  assign d_addr = d_addr_q;

  // Step sequencer: one-hot ring, frozen once the core has halted.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) step_q <= 7'b0000001;
    else        step_q <= step_d;
  end

  always_comb begin
    step_d = step_q;
    if (!trap_q) step_d = {step_q[5:0], step_q[6]};
  end

  always_comb begin
    step_2 = step_q[2];
    step_4 = step_q[4];
    step_6 = step_q[6];
  end

  always_comb begin
    regs[0] = '0;
    for (int i = 1; i < 32; i++) regs[i] = regs_q[i];
  end

  assign opcode   = ins_q[6:0];
  assign alu_func = ins_q[14:12];
  assign rd       = ins_q[11:7];
  assign rs1      = ins_q[19:15];
  assign rs2      = ins_q[24:20];
  assign rs1_val  = regs[rs1];
  assign rs2_val  = regs[rs2];
  assign alu_alt  = (opcode == OPC_OP || (opcode == OPC_OP_IMM && alu_func[1:0] == 2'b01)) ? ins_q[30] : 1'b0;
  assign alu_left = (opcode == OPC_AUIPC || opcode == OPC_JAL || opcode == OPC_BRANCH) ? pc_q : rs1_val;
  assign alu_right = (opcode == OPC_OP) ? rs2_val : imm;
  assign sum      = alu_left + imm;
  assign ea       = rs1_val[13:0] + imm[13:0];

  always_comb begin
    case (opcode)
      OPC_LUI, OPC_AUIPC: imm = {ins_q[31:12], 12'b0};
      OPC_JAL:    imm = {{12{ins_q[31]}}, ins_q[19:12], ins_q[20], ins_q[30:21], 1'b0};
      OPC_BRANCH: imm = {{20{ins_q[31]}}, ins_q[7], ins_q[30:25], ins_q[11:8], 1'b0};
      OPC_STORE:  imm = {{21{ins_q[31]}}, ins_q[30:25], ins_q[11:7]};
      default:    imm = {{21{ins_q[31]}}, ins_q[30:20]};
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (alu_func)
      3'd0: alu_res = alu_alt ? alu_left - alu_right : alu_left + alu_right;
      3'd1: alu_res = alu_left << alu_right[4:0];
      3'd2: alu_res = {31'b0, $signed(alu_left) < $signed(alu_right)};
      3'd3: alu_res = {31'b0, alu_left < alu_right};
      3'd4: alu_res = alu_left ^ alu_right;
      3'd5: alu_res = alu_alt ? $unsigned($signed(alu_left) >>> alu_right[4:0]) : alu_left >> alu_right[4:0];
      3'd6: alu_res = alu_left | alu_right;
      default: alu_res = alu_left & alu_right;
    endcase
  end

  always_comb begin
    br_take = 1'b0;
    case (alu_func)
      3'd0: br_take = rs1_val == rs2_val;
      3'd1: br_take = rs1_val != rs2_val;
      3'd4: br_take = $signed(rs1_val) < $signed(rs2_val);
      3'd5: br_take = $signed(rs1_val) >= $signed(rs2_val);
      3'd6: br_take = rs1_val < rs2_val;
      3'd7: br_take = rs1_val >= rs2_val;
      default: br_take = 1'b0;
    endcase
  end

  assign funct7_ok = (ins_q[31:25] == 7'h00) ||
                     (ins_q[31:25] == 7'h20 && (alu_func == 3'd0 || alu_func == 3'd5));

  always_comb begin
    known     = 1'b1;
    writes_rd = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_OP_IMM: writes_rd = 1'b1;
      OPC_OP:     writes_rd = funct7_ok;
      OPC_SYSTEM: writes_rd = alu_func != 3'd0;
      OPC_BRANCH, OPC_STORE, OPC_FENCE: writes_rd = 1'b0;
      default:    known = 1'b0;
    endcase
  end

  assign illegal = !known || (opcode == OPC_OP && !funct7_ok);
`ifdef TWITCHCORE_ILLEGAL_TRAP_EN
  assign illegal_halt = illegal;
`else
  assign illegal_halt = 1'b0;
`endif

  assign is_ecall    = opcode == OPC_SYSTEM && alu_func == 3'd0 && ins_q[31:20] == 12'h000;
  assign is_ebreak   = opcode == OPC_SYSTEM && alu_func == 3'd0 && ins_q[31:20] == 12'h001;
  assign is_mret     = opcode == OPC_SYSTEM && alu_func == 3'd0 && ins_q[31:20] == 12'h302;
  assign is_csr      = opcode == OPC_SYSTEM && alu_func != 3'd0;
  assign csr_mepc_wr = is_csr && ins_q[31:20] == 12'h341;
  assign halt        = is_ecall || is_ebreak || illegal_halt;
  assign csr_src     = alu_func[2] ? {27'b0, rs1} : rs1_val;

  always_comb begin
    case (alu_func[1:0])
      2'b01:   csr_wdata = csr_src;
      2'b10:   csr_wdata = mepc_q | csr_src;
      2'b11:   csr_wdata = mepc_q & ~csr_src;
      default: csr_wdata = mepc_q;
    endcase
  end

  // Load lane selection uses the byte offset captured alongside d_addr.
  always_comb begin
    case (ea_lo_q)
      2'd0:    load_byte = d_data[7:0];
      2'd1:    load_byte = d_data[15:8];
      2'd2:    load_byte = d_data[23:16];
      default: load_byte = d_data[31:24];
    endcase
    load_half = ea_lo_q[1] ? d_data[31:16] : d_data[15:0];
    case (alu_func)
      3'd0:    load_val = {{24{load_byte[7]}}, load_byte};
      3'd1:    load_val = {{16{load_half[15]}}, load_half};
      3'd4:    load_val = {24'b0, load_byte};
      3'd5:    load_val = {16'b0, load_half};
      default: load_val = d_data;
    endcase
  end

  always_comb begin
    pc_d     = pc_q;
    ins_d    = ins_q;
    mepc_d   = mepc_q;
    alu_d    = alu_q;
    target_d = target_q;
    take_d   = take_q;
    d_addr_d = d_addr_q;
    ea_lo_d  = ea_lo_q;
    pend_d   = pend_q;
    trap_d   = trap_q;
    if (step_2) ins_d = i_data;
    if (step_4) begin
      d_addr_d = ea[13:2];
      ea_lo_d  = ea[1:0];
      pend_d   = writes_rd && !illegal;
      take_d   = opcode == OPC_JAL || opcode == OPC_JALR || (opcode == OPC_BRANCH && br_take);
      target_d = (opcode == OPC_JALR) ? ((rs1_val + imm) & ~32'd1) : sum;
      case (opcode)
        OPC_LUI:               alu_d = imm;
        OPC_AUIPC:             alu_d = sum;
        OPC_JAL, OPC_JALR:     alu_d = pc_q + 32'd4;
        OPC_OP, OPC_OP_IMM:    alu_d = alu_res;
        default:               alu_d = '0;
      endcase
    end
    if (step_6) begin
      pend_d = 1'b0;
      if (halt)         trap_d = 1'b1;
      else if (is_mret) pc_d = mepc_q;
      else if (take_q)  pc_d = target_q;
      else              pc_d = pc_q + 32'd4;
      if (csr_mepc_wr && !halt) mepc_d = csr_wdata;
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      pc_q     <= RESET_PC;
      ins_q    <= '0;
      mepc_q   <= '0;
      alu_q    <= '0;
      target_q <= '0;
      take_q   <= 1'b0;
      d_addr_q <= '0;
      ea_lo_q  <= '0;
      pend_q   <= 1'b0;
      trap_q   <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      ins_q    <= ins_d;
      mepc_q   <= mepc_d;
      alu_q    <= alu_d;
      target_q <= target_d;
      take_q   <= take_d;
      d_addr_q <= d_addr_d;
      ea_lo_q  <= ea_lo_d;
      pend_q   <= pend_d;
      trap_q   <= trap_d;
    end
  end

  // Register file is not reset; reset still blocks any in-flight writeback.
  assign rf_we    = step_6 && pend_q && !halt && rd != 5'd0;
  assign rf_wdata = (opcode == OPC_LOAD) ? load_val : alu_q;

  always_ff @(posedge clk) begin
    if (!resetn && rf_we) regs_q[rd] <= rf_wdata;
  end
endmodule

// File: tb/tb_twitchcore_cpu.sv
// Directed bench for twitchcore_cpu: runs a small hand-assembled RV32I program from a 4096-word memory model.
module tb_twitchcore_cpu;
  logic        clk;
  logic        resetn;
  logic        trap;
  logic [11:0] i_addr;
  logic [31:0] i_data;
  logic [11:0] d_addr;
  logic [31:0] d_data;
  logic [31:0] mem [0:4095];
  int compared;
  int mismatched;
  int cyc;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] SYS    = 7'b1110011;

  twitchcore_cpu dut (
    .clk    (clk),
    .resetn (resetn),
    .trap   (trap),
    .i_addr (i_addr),
    .i_data (i_data),
    .d_addr (d_addr),
    .d_data (d_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: one edge of latency on both ports.
  always @(posedge clk) begin
    i_data <= mem[i_addr];
    d_data <= mem[d_addr];
  end

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [31:0] rs1,
                                        input logic [31:0] f3, input logic [31:0] rd, input logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [31:0] f7, input logic [31:0] rs2, input logic [31:0] rs1,
                                        input logic [31:0] f3, input logic [31:0] rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], OP_REG};
  endfunction

  function automatic logic [31:0] enc_u(input logic [31:0] imm20, input logic [31:0] rd, input logic [6:0] op);
    return {imm20[19:0], rd[4:0], op};
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] off, input logic [31:0] rs2,
                                        input logic [31:0] rs1, input logic [31:0] f3);
    return {off[12], off[10:5], rs2[4:0], rs1[4:0], f3[2:0], off[4:1], off[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] off, input logic [31:0] rd);
    return {off[20], off[10:1], off[11], off[19:12], rd[4:0], 7'b1101111};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    resetn     = 1'b1;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0000_0013;
    mem[12'h100] = 32'h80FF_7F01;

    mem[0]  = enc_i(5, 0, 0, 1, OP_IMM);           // addi x1,x0,5
    mem[1]  = enc_u(32'h12345, 2, 7'b0110111);     // lui  x2,0x12345
    mem[2]  = enc_i(32'h400, 0, 2, 4, LOAD);       // lw   x4,0x400(x0)
    mem[3]  = enc_i(32'h403, 0, 0, 5, LOAD);       // lb   x5,0x403(x0)
    mem[4]  = enc_i(32'h403, 0, 4, 6, LOAD);       // lbu  x6,0x403(x0)
    mem[5]  = enc_i(32'h402, 0, 1, 7, LOAD);       // lh   x7,0x402(x0)
    mem[6]  = enc_b(8, 0, 0, 0);                   // beq  x0,x0,+8
    mem[7]  = enc_i(0, 0, 0, 5, OP_IMM);           // addi x5,x0,0 (skipped)
    mem[8]  = enc_j(8, 0);                         // jal  x0,+8
    mem[9]  = enc_j(8, 0);                         // jal  x0,+8
    mem[10] = enc_j(-4, 1);                        // jal  x1,-4
    mem[11] = enc_i(-3, 0, 0, 12, OP_IMM);         // addi x12,x0,-3
    mem[12] = enc_r(32'h20, 2, 12, 0, 13);         // sub  x13,x12,x2
    mem[13] = enc_i(32'h401, 12, 5, 14, OP_IMM);   // srai x14,x12,1
    mem[14] = enc_i(28, 12, 5, 15, OP_IMM);        // srli x15,x12,28
    mem[15] = enc_r(0, 0, 12, 2, 16);              // slt  x16,x12,x0
    mem[16] = enc_r(0, 12, 0, 3, 17);              // sltu x17,x0,x12
    mem[17] = enc_u(0, 18, 7'b0010111);            // auipc x18,0
    mem[18] = enc_i(20, 18, 0, 20, OP_IMM);        // addi x20,x18,20
    mem[19] = enc_i(32'h341, 20, 1, 19, SYS);      // csrrw x19,mepc,x20
    mem[20] = 32'h3020_0073;                       // mret
    mem[21] = enc_i(0, 0, 0, 5, OP_IMM);           // skipped
    mem[22] = enc_i(8, 20, 0, 21, 7'b1100111);     // jalr x21,8(x20)
    mem[23] = enc_i(0, 0, 0, 5, OP_IMM);           // skipped
    mem[24] = enc_b(8, 12, 12, 1);                 // bne  x12,x12,+8 (not taken)
    mem[25] = enc_b(8, 0, 12, 4);                  // blt  x12,x0,+8 (taken)
    mem[26] = enc_i(0, 0, 0, 5, OP_IMM);           // skipped
    mem[27] = enc_b(8, 12, 0, 7);                  // bgeu x0,x12,+8 (not taken)
    mem[28] = enc_i(1, 0, 0, 3, OP_IMM);           // addi x3,x0,1
    mem[29] = 32'h0000_0073;                       // ecall

    applyStimulus(3);
    checkOutput("reset_pc", dut.pc, 32'h8000_0000);
    checkOutput("reset_i_addr", {20'b0, i_addr}, 32'h0);
    checkOutput("reset_trap", {31'b0, trap}, 32'h0);
    checkOutput("reset_d_addr", {20'b0, d_addr}, 32'h0);

    @(negedge clk);
    resetn = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      applyStimulus(1);
      checkOutput("i_addr_hold", {20'b0, i_addr}, 32'h0);
    end
    applyStimulus(1);
    checkOutput("i_addr_next", {20'b0, i_addr}, 32'h1);

    applyStimulus(7);
    checkOutput("addi_x1", dut.regs[1], 32'd5);
    checkOutput("lui_x2", dut.regs[2], 32'h1234_5000);

    cyc = 0;
    while (!trap && cyc < 2000) begin
      applyStimulus(1);
      cyc++;
    end
    checkOutput("trap_rise", {31'b0, trap}, 32'h1);
    checkOutput("trap_in_time", {31'b0, ($time < 50000)}, 32'h1);
    checkOutput("gp_pass", dut.regs[3], 32'h1);
    checkOutput("lw_x4", dut.regs[4], 32'h80FF_7F01);
    checkOutput("lb_x5", dut.regs[5], 32'hFFFF_FF80);
    checkOutput("lbu_x6", dut.regs[6], 32'h0000_0080);
    checkOutput("lh_x7", dut.regs[7], 32'hFFFF_80FF);
    checkOutput("jal_link_x1", dut.regs[1], 32'h8000_002C);
    checkOutput("addi_neg_x12", dut.regs[12], 32'hFFFF_FFFD);
    checkOutput("sub_x13", dut.regs[13], 32'hEDCB_AFFD);
    checkOutput("srai_x14", dut.regs[14], 32'hFFFF_FFFE);
    checkOutput("srli_x15", dut.regs[15], 32'h0000_000F);
    checkOutput("slt_x16", dut.regs[16], 32'h1);
    checkOutput("sltu_x17", dut.regs[17], 32'h1);
    checkOutput("auipc_x18", dut.regs[18], 32'h8000_0044);
    checkOutput("csr_rd_x19", dut.regs[19], 32'h0);
    checkOutput("jalr_link_x21", dut.regs[21], 32'h8000_005C);
    checkOutput("x0_zero", dut.regs[0], 32'h0);
    checkOutput("ecall_pc", dut.pc, 32'h8000_0074);

    applyStimulus(20);
    checkOutput("frozen_trap", {31'b0, trap}, 32'h1);
    checkOutput("frozen_pc", dut.pc, 32'h8000_0074);
    checkOutput("frozen_gp", dut.regs[3], 32'h1);
    checkOutput("frozen_x21", dut.regs[21], 32'h8000_005C);

    resetn = 1'b1;
    #1;
    checkOutput("rereset_trap", {31'b0, trap}, 32'h0);
    checkOutput("rereset_pc", dut.pc, 32'h8000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/twitchcore_cpu.md
# twitchcore_cpu

Multi-cycle RV32I integer core (`twitchcore`) fetching from a word-addressed synchronous instruction port and loading from a separate word-addressed synchronous data port. It is the CPU of the design and is driven by an external 4096 x 32 memory model. It executes the riscv-tests `rv32ui-p-*` programs and raises `trap` on ECALL, which ends simulation. The pass/fail result is reported in `regs[3]` (gp).

## Interface
- No parameters.
- `clk`  in  1  single clock; all state updates on rising edge.
- `resetn`  in  1  reset; asynchronous, active-high despite the name.
- `trap`  out  1  halt flag; sticky until reset.
- `i_addr`  out  12  instruction word address = `pc[13:2]`; combinational from `pc`.
- `i_data`  in  32  instruction word; registered by memory one edge after `i_addr`.
- `d_addr`  out  12  data word address = effective address `[13:2]`; registered.
- `d_data`  in  32  data word; registered by memory one edge after `d_addr`.

Internal names the bench probes hierarchically: `ins`, `pc`, `opcode`, `alu_func`, `alu_alt`, `alu_left`, `imm`, `pend`, `regs[0:31]`, `step_6`.

## Operation
- **Step sequencer:** one-hot `step_0`..`step_6`, advancing one step per clock. `step_6` wraps to `step_0`. The sequencer freezes while `trap`=1.
- **step_0:** `i_addr` is stable from `pc`.
- **step_1:** memory has latched the instruction word.
- **step_2:** `ins` <= `i_data`.
- **step_3:** decode.
  - `opcode` = `ins[6:0]`.
  - `alu_func` = funct3.
  - `alu_alt` = `ins[30]` for OP, and for OP-IMM shifts only.
  - `imm` is sign-extended per I/S/B/U/J format.
  - `alu_left` = `regs[rs1]`, or `pc` for AUIPC/JAL/branch targets.
- **step_4:** ALU result is computed. `d_addr` <= (`rs1`+`imm`)[13:2]. `pend` is set if the instruction writes `rd`.
- **step_5:** memory latches the data word.
- **step_6:** writeback and `pc` update. `pend` is cleared.
- **Load writeback:** LW takes the whole word. LB/LBU/LH/LHU select the byte/half lane by address bits [1:0], then sign- or zero-extend.
- **PC update:** `pc`+4, branch/JAL target, or (`rs1`+`imm`)&~1 for JALR.
- **Supported instructions:** LUI, AUIPC, JAL, JALR, all branches, all loads, OP-IMM, OP (ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND), FENCE (no-op).
- **Stores:** no write port, so stores compute an address and change nothing else.
- **SYSTEM instructions:**
  - ECALL sets `trap`.
  - MRET sets `pc` <= `mepc`.
  - CSRRW/CSRRS/CSRRC(/I) write 0 to `rd`. Writes to CSR 0x341 update `mepc`; all other CSRs read 0 and ignore writes. EBREAK sets `trap`.
- **Register file:** `regs[0]` always reads 0 and writes to it are discarded. 32-bit wrap-around arithmetic. Shift amount is the low 5 bits.
- Misaligned or out-of-range addresses are silently truncated to 12 word bits; no exceptions are raised.

## Timing
- **Reset (asynchronous while `resetn`=1):**
  - `pc`=0x80000000, so `i_addr`=0.
  - `step_0`=1, other steps 0.
  - `trap`=0, `d_addr`=0, `ins`=0, `pend`=0, `mepc`=0.
  - `regs` are not reset, except x0 which is hard-wired to 0.
- Release is sampled at a rising edge; the first fetch starts in `step_0` of the following cycle.
- Exactly 7 cycles per instruction, for every instruction type.
- **`trap`** rises at the `step_6` edge of the ECALL instruction. After that, no register, `pc` or step changes occur.
- **Reset mid-instruction:** aborts immediately; no partial writeback.
- **Address stability:** `i_addr` is held stable from `step_0` through `step_2`. `d_addr` is held stable from `step_4` through `step_6`.

## Configuration
- **`TWITCHCORE_ILLEGAL_TRAP_EN`**
  - Defined: any unrecognised opcode, or an OP with invalid funct7, sets `trap` at `step_6`.
  - Undefined: such instructions behave as NOPs (`pc`+4, no writeback).

## Test plan
- **Reset:** hold `resetn`=1 for 3 cycles.
  - During reset: `pc`=0x80000000, `i_addr`=0, `trap`=0.
  - After release: `i_addr` stays 0 for 7 cycles, then becomes 1.
- **ADDI/LUI:** program `addi x1,x0,5`; `lui x2,0x12345`.
  - After 14 cycles: `regs[1]`=5, `regs[2]`=0x12345000.
- **Loads:** mem[0x100]=0x80FF7F01; `lw`, `lb`, `lbu` and `lh` at byte offsets 0x400, 0x403 and 0x402.
  - `lw` gives 0x80FF7F01.
  - `lb` at 0x403 gives 0xFFFFFF80.
  - `lbu` at 0x403 gives 0x80.
  - `lh` at 0x402 gives 0xFFFF80FF.
- **Branch/JAL:** `beq x0,x0,+8` skips the next instruction; `jal x1,-4` writes `pc`+4 into x1.
- **rv32ui-p-lw image:** `trap` rises and `regs[3]`=1 well before 50000 ns with a 10 ns clock.
- **ECALL halt:** after `trap`, `pc` and `regs` stay frozen for 20 cycles. Reset clears `trap`.
